instr_ctrl: RTL and testbench
=============================

Name: instr_ctrl

Overview:
- Instruction-sequencing FSM for the 16-bit accumulator CPU. It sits directly upstream of the instruction register and drives its load strobe (load_ir).
- Consumes the registered opcode field (IR bits [15:12]) and the accumulator zero flag.
- Emits the per-cycle control strobes for the program counter, memory, accumulator/ALU and data-bus driver.
- Every instruction runs in a fixed 8-state sequence; HLT parks the machine.

Parameters:
OPC_W, 4, opcode width taken from IR[15:12]; the opcode encodings below assume 4.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-low; state and outputs forced to reset values immediately
ena  input  1  run enable, sampled only at instruction boundary (state IDLE / S7 exit)
opcode  input  OPC_W  instruction opcode from IR[15:12], valid from S2 onward
zero  input  1  accumulator == 0 flag
load_ir  output  1  load instruction register from data bus
inc_pc  output  1  increment program counter
load_pc  output  1  load PC from IR address field (jump)
rd  output  1  memory read enable
wr  output  1  memory write strobe
load_acc  output  1  accumulator captures ALU result
datactl  output  1  drive accumulator onto data bus
halt  output  1  machine halted
illegal  output  1  illegal-opcode trap (see Optional Feature)

Behaviour:
- Opcodes: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP, 8-15 undefined (NOP by default).
- States: IDLE, S0..S7, HALT. One state per clock; outputs are a combinational decode of state, opcode and zero. Strobes not listed for a state are 0.
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0. On rst release, the first edge is evaluated from IDLE.
- IDLE: all outputs 0. ena=1 -> S0; otherwise stay in IDLE.
- S0 fetch: rd=1.
- S1 load: rd=1, load_ir=1. The IR captures the instruction at the end of S1.
- S2: inc_pc=1.
- S3 decode, by opcode:
  - HLT: halt=1, next state HALT.
  - All other opcodes: no strobes, next state S4.
- S4, by opcode:
  - ADD/AND/XOR/LDA: rd=1 (operand fetch).
  - STO: datactl=1.
  - JMP: load_pc=1.
  - SKZ: inc_pc=zero, i.e. skip the next instruction only when zero=1 during S4.
- S5, by opcode:
  - ADD/AND/XOR/LDA: rd=1, load_acc=1.
  - STO: datactl=1, wr=1 (exactly one-cycle write pulse).
- S6: for STO, datactl=1 (bus hold after write); otherwise no strobes.
- S7: no strobes. ena=1 -> S0; ena=0 -> IDLE.
- HALT: halt=1, all other strobes 0. Held until rst; ena is ignored.
- Guaranteed exclusions:
  - wr and rd are never both 1.
  - load_pc and inc_pc are never both 1.
  - At most one inc_pc pulse per instruction, except SKZ with zero=1, which gives two (S2 and S4).
- Instruction latency: 8 cycles from S0 to S7. Back-to-back instructions with ena held high run with no IDLE gap.
- ena deasserted mid-instruction has no effect until S7.
- opcode changes outside S3..S6 are ignored.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: opcodes 8-15 in S3 assert illegal=1 and halt=1 and transition to HALT. illegal stays 1 while in HALT and clears only on rst.
- Undefined: opcodes 8-15 execute as NOP (S4..S7 with no strobes), and illegal is tied to 0.

Test Plan:
- rst=0 mid-S5 of an ADD -> all outputs 0 immediately, without waiting for a clock edge. After release with ena=1: IDLE, then S0 (rd=1) on the next edge.
- ena=1, opcode=2 (ADD) -> strobe sequence per cycle: rd, rd+load_ir, inc_pc, none, rd, rd+load_acc, none, none. Then S0 again; total 8 cycles.
- opcode=6 (STO) -> datactl=1 for exactly 3 cycles (S4-S6); wr=1 only in S5; rd never 1 in S4-S6.
- opcode=1 (SKZ) with zero=1 -> inc_pc pulses in S2 and S4. With zero=0 -> inc_pc pulses in S2 only.
- opcode=0 (HLT) -> halt=1 from S3 onward and stays 1 for 20+ cycles with ena toggling. rst=0 clears it.
- opcode=9, with ILLEGAL_TRAP_EN defined -> illegal=1 and halt=1 from S3. Without the macro -> 8-cycle NOP, illegal=0. Separately, ena=0 during S4 -> the instruction completes through S7, then IDLE.

Source files
------------

// File: rtl/instr_ctrl.sv
// Instruction-sequencing FSM for the 16-bit accumulator CPU: fixed 8-state sequence per instruction.
// Optional macro ILLEGAL_TRAP_EN: opcodes 8-15 trap to HALT with illegal=1 instead of running as NOP.
module instr_ctrl #(
  parameter int unsigned OPC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  output logic             load_ir,
  output logic             inc_pc,
  output logic             load_pc,
  output logic             rd,
  output logic             wr,
  output logic             load_acc,
  output logic             datactl,
  output logic             halt,
  output logic             illegal
);

  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SKZ = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_AND = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_STO = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(7);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    S0   = 4'd1,
    S1   = 4'd2,
    S2   = 4'd3,
    S3   = 4'd4,
    S4   = 4'd5,
    S5   = 4'd6,
    S6   = 4'd7,
    S7   = 4'd8,
    HALT = 4'd9
  } state_t;

  state_t state, next_state;
  logic   is_alu;

  assign is_alu = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);

`ifdef ILLEGAL_TRAP_EN
  logic is_undef;
  logic trap_q;

  assign is_undef = (opcode > OP_JMP);

  // Remembers that HALT was entered through a trap so illegal holds until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trap_q <= 1'b0;
    end else if (state == S3 && is_undef) begin
      trap_q <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and strobe decode from state, opcode and zero.
  always_comb begin
    next_state = state;
    load_ir    = 1'b0;
    inc_pc     = 1'b0;
    load_pc    = 1'b0;
    rd         = 1'b0;
    wr         = 1'b0;
    load_acc   = 1'b0;
    datactl    = 1'b0;
    halt       = 1'b0;
    illegal    = 1'b0;
    case (state)
      IDLE: if (ena) next_state = S0;
      S0: begin
        rd         = 1'b1;
        next_state = S1;
      end
      S1: begin
        rd         = 1'b1;
        load_ir    = 1'b1;
        next_state = S2;
      end
      S2: begin
        inc_pc     = 1'b1;
        next_state = S3;
      end
      S3: begin
        next_state = S4;
        if (opcode == OP_HLT) begin
          halt       = 1'b1;
          next_state = HALT;
        end
`ifdef ILLEGAL_TRAP_EN
        else if (is_undef) begin
          halt       = 1'b1;
          illegal    = 1'b1;
          next_state = HALT;
        end
`endif
      end
      S4: begin
        next_state = S5;
        if (is_alu)                rd      = 1'b1;
        else if (opcode == OP_STO) datactl = 1'b1;
        else if (opcode == OP_JMP) load_pc = 1'b1;
        else if (opcode == OP_SKZ) inc_pc  = zero;
      end
      S5: begin
        next_state = S6;
        if (is_alu) begin
          rd       = 1'b1;
          load_acc = 1'b1;
        end else if (opcode == OP_STO) begin
          datactl  = 1'b1;
          wr       = 1'b1;
        end
      end
      S6: begin
        next_state = S7;
        datactl    = (opcode == OP_STO);
      end
      S7: next_state = ena ? S0 : IDLE;
      HALT: begin
        halt = 1'b1;
`ifdef ILLEGAL_TRAP_EN
        illegal = trap_q;
`endif
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_ctrl.sv
// Self-checking bench for instr_ctrl: directed vector table, hand sequences and a randomized model run.
module tb_instr_ctrl;

  typedef logic [8:0] outv_t;

  localparam outv_t LIR  = 9'b100000000;
  localparam outv_t INC  = 9'b010000000;
  localparam outv_t LPC  = 9'b001000000;
  localparam outv_t RD   = 9'b000100000;
  localparam outv_t WR   = 9'b000010000;
  localparam outv_t LACC = 9'b000001000;
  localparam outv_t DCTL = 9'b000000100;
  localparam outv_t HLT  = 9'b000000010;
  localparam outv_t ILL  = 9'b000000001;
  localparam outv_t NONE = 9'b000000000;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    string            name;
    logic [3:0]       op;
    logic             z;
    outv_t [0:7]      seq;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       zero = 1'b0;
  logic load_ir, inc_pc, load_pc, rd, wr, load_acc, datactl, halt, illegal;

  int checks = 0;
  int errors = 0;

  instr_ctrl #(.OPC_W(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
    .load_ir(load_ir), .inc_pc(inc_pc), .load_pc(load_pc), .rd(rd), .wr(wr),
    .load_acc(load_acc), .datactl(datactl), .halt(halt), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic outv_t outs();
    return {load_ir, inc_pc, load_pc, rd, wr, load_acc, datactl, halt, illegal};
  endfunction

  task automatic check(input string nm, input outv_t act, input outv_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b (ir,inc,lpc,rd,wr,lacc,dctl,halt,ill) t=%0t", nm, act, exp, $time);
    end
  endtask

  // Drive inputs on the falling edge, then check the decode before the next rising edge.
  task automatic drive_check(input logic e, input logic [3:0] op, input logic z,
                             input outv_t exp, input string nm);
    @(negedge clk);
    ena = e; opcode = op; zero = z;
    #1;
    check(nm, outs(), exp);
  endtask

  task automatic do_reset(input logic e);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_outputs", outs(), NONE);
    @(negedge clk);
    ena = e;
    rst = 1'b1;
    #1;
    check("idle_after_reset", outs(), NONE);
  endtask

  function automatic vec_t mkv(input string n, input logic [3:0] op, input logic z,
                               input outv_t s4, input outv_t s5, input outv_t s6);
    vec_t v;
    v.name = n; v.op = op; v.z = z;
    v.seq = {RD, RD | LIR, INC, NONE, s4, s5, s6, NONE};
    return v;
  endfunction

  // Reference model: instruction phase -1 idle, 0..7 within instruction, 8 halted.
  function automatic outv_t model_out(input int ph, input logic [3:0] op, input logic z, input bit trapped);
    bit alu;
    alu = (op >= 4'd2 && op <= 4'd5);
    if (ph < 0) return NONE;
    if (ph == 8) return trapped ? (HLT | ILL) : HLT;
    case (ph)
      0: return RD;
      1: return RD | LIR;
      2: return INC;
      3: begin
        if (op == 4'd0) return HLT;
        if (TRAP && op >= 4'd8) return HLT | ILL;
        return NONE;
      end
      4: begin
        if (alu) return RD;
        if (op == 4'd6) return DCTL;
        if (op == 4'd7) return LPC;
        if (op == 4'd1) return z ? INC : NONE;
        return NONE;
      end
      5: begin
        if (alu) return RD | LACC;
        if (op == 4'd6) return DCTL | WR;
        return NONE;
      end
      6: return (op == 4'd6) ? DCTL : NONE;
      default: return NONE;
    endcase
  endfunction

  vec_t vecs[$];

  initial begin
    int   ph;
    bit   trapped;
    int   halted_cnt;
    logic e, z;
    logic [3:0] cur_op;
    outv_t o;

    vecs.push_back(mkv("ADD",    4'd2, 1'b0, RD,   RD | LACC,   NONE));
    vecs.push_back(mkv("AND",    4'd3, 1'b1, RD,   RD | LACC,   NONE));
    vecs.push_back(mkv("XOR",    4'd4, 1'b0, RD,   RD | LACC,   NONE));
    vecs.push_back(mkv("LDA",    4'd5, 1'b1, RD,   RD | LACC,   NONE));
    vecs.push_back(mkv("STO",    4'd6, 1'b0, DCTL, DCTL | WR,   DCTL));
    vecs.push_back(mkv("JMP",    4'd7, 1'b1, LPC,  NONE,        NONE));
    vecs.push_back(mkv("SKZ_z1", 4'd1, 1'b1, INC,  NONE,        NONE));
    vecs.push_back(mkv("SKZ_z0", 4'd1, 1'b0, NONE, NONE,        NONE));
`ifndef ILLEGAL_TRAP_EN
    vecs.push_back(mkv("NOP9",   4'd9, 1'b1, NONE, NONE,        NONE));
`endif

    #1;
    check("reset_held", outs(), NONE);

    // Back-to-back table run with ena held high.
    do_reset(1'b1);
    foreach (vecs[k]) begin
      for (int i = 0; i < 8; i++) begin
        drive_check(1'b1, vecs[k].op, vecs[k].z, vecs[k].seq[i], $sformatf("%s_S%0d", vecs[k].name, i));
      end
    end
    drive_check(1'b1, 4'd2, 1'b0, RD, "next_S0_no_gap");

    // Asynchronous reset in the middle of S5 of an ADD.
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) drive_check(1'b1, 4'd2, 1'b0, vecs[0].seq[i], "add_pre_S5");
    drive_check(1'b1, 4'd2, 1'b0, RD | LACC, "add_S5");
    #1 rst = 1'b0;
    #1 check("async_rst_mid_S5", outs(), NONE);
    @(negedge clk);
    ena = 1'b1; rst = 1'b1;
    #1 check("idle_after_async_rst", outs(), NONE);
    drive_check(1'b1, 4'd2, 1'b0, RD, "S0_after_async_rst");

    // HLT parks the machine regardless of ena until reset.
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) drive_check(1'b1, 4'd0, 1'b0, vecs[0].seq[i], "hlt_pre");
    drive_check(1'b1, 4'd0, 1'b0, HLT, "hlt_S3");
    for (int i = 0; i < 22; i++) drive_check(logic'(i % 2), 4'($urandom_range(0, 15)), 1'b0, HLT, "hlt_hold");
    do_reset(1'b0);

    // ena dropped in S4 lets the instruction finish, then IDLE.
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) drive_check(1'b1, 4'd2, 1'b0, vecs[0].seq[i], "ena_drop_pre");
    drive_check(1'b0, 4'd2, 1'b0, RD,        "ena_drop_S4");
    drive_check(1'b0, 4'd2, 1'b0, RD | LACC, "ena_drop_S5");
    drive_check(1'b0, 4'd2, 1'b0, NONE,      "ena_drop_S6");
    drive_check(1'b0, 4'd2, 1'b0, NONE,      "ena_drop_S7");
    for (int i = 0; i < 3; i++) drive_check(1'b0, 4'd2, 1'b0, NONE, "ena_drop_idle");
    drive_check(1'b1, 4'd2, 1'b0, NONE, "idle_sees_ena");
    drive_check(1'b1, 4'd2, 1'b0, RD,   "restart_S0");

`ifdef ILLEGAL_TRAP_EN
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) drive_check(1'b1, 4'd9, 1'b0, vecs[0].seq[i], "trap_pre");
    drive_check(1'b1, 4'd9, 1'b0, HLT | ILL, "trap_S3");
    for (int i = 0; i < 6; i++) drive_check(logic'(i % 2), 4'd2, 1'b0, HLT | ILL, "trap_hold");
    do_reset(1'b1);
`endif

    // Randomized run against the reference model.
    do_reset(1'b1);
    ph = 0; trapped = 1'b0; halted_cnt = 0; cur_op = 4'd0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 59) == 0 || halted_cnt > 30) begin
        e = logic'($urandom_range(0, 1));
        do_reset(e);
        ph = e ? 0 : -1; trapped = 1'b0; halted_cnt = 0;
        continue;
      end
      e = ($urandom_range(0, 3) != 0);
      z = logic'($urandom_range(0, 1));
      if (ph < 3 || ph > 6) cur_op = 4'($urandom_range(0, 15));
      drive_check(e, cur_op, z, model_out(ph, cur_op, z, trapped), "random_model");
      o = outs();
      check("excl_rd_wr", o & (RD | WR) & {9{(o & RD) != 0}} & {9{(o & WR) != 0}}, NONE);
      check("excl_inc_lpc", o & (INC | LPC) & {9{(o & INC) != 0}} & {9{(o & LPC) != 0}}, NONE);
      if (ph == 8) halted_cnt++;
      else if (ph < 0) ph = e ? 0 : -1;
      else if (ph == 3 && cur_op == 4'd0) ph = 8;
      else if (ph == 3 && TRAP && cur_op >= 4'd8) begin ph = 8; trapped = 1'b1; end
      else if (ph == 7) ph = e ? 0 : -1;
      else ph++;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
